// File: rtl/loop_index_pkg.sv
// Shared types and constants for the loop index generator: step operations,
// FSM state encoding and the op field width.
package loop_index_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      ADD = 2'd0,
      MUL = 2'd1,
      SHL = 2'd2
   } step_op_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/loop_index_step.sv
// Combinational step unit: computes the next loop index from the current one
// and decides whether the sequence must terminate (overflow, no progress, limit).
module loop_index_step
   import loop_index_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] idx,
   input  logic [WIDTH-1:0] step,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] next,
   output logic             ovf,
   output logic             term
);

   localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] shifted;

   // Double-width results keep every bit that would fall off a WIDTH-bit result.
   assign sum     = {1'b0, idx} + {1'b0, step};
   assign prod    = {{WIDTH{1'b0}}, idx} * {{WIDTH{1'b0}}, step};
   assign shifted = {{WIDTH{1'b0}}, idx} << step[SHW-1:0];

   always_comb begin
      next = sum[WIDTH-1:0];
      ovf  = sum[WIDTH];
      case (step_op_t'(op))
         MUL: begin
            next = prod[WIDTH-1:0];
            ovf  = |prod[2*WIDTH-1:WIDTH];
         end
         SHL: begin
            next = shifted[WIDTH-1:0];
            ovf  = (|shifted[2*WIDTH-1:WIDTH]) | (step >= WIDTH_V);
         end
         default: ;
      endcase
      // A next value that does not exceed the current one means the loop stalled.
      term = ovf | (next <= idx) | (next >= limit);
   end

endmodule

// File: rtl/loop_index_gen.sv
// Hardware for-loop index generator streaming indices over valid/ready.
// Optional element counter output enabled by defining LOOP_INDEX_GEN_COUNT_EN.
module loop_index_gen
   import loop_index_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_init,
   input  logic [WIDTH-1:0] i_limit,
   input  logic [WIDTH-1:0] i_step,
   input  logic [OP_W-1:0]  i_op,
   output logic             o_busy,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_index,
   output logic             o_last,
   output logic             o_done,
   output logic             o_err
`ifdef LOOP_INDEX_GEN_COUNT_EN
   ,
   output logic [WIDTH-1:0] o_count
`endif
);

   localparam logic [0:0] ST_IDLE = IDLE;
   localparam logic [0:0] ST_RUN  = RUN;

   logic [0:0]       state;
   logic [WIDTH-1:0] limit_q;
   logic [WIDTH-1:0] step_q;
   logic [OP_W-1:0]  op_q;
   logic [WIDTH-1:0] index_q;
   logic             valid_q;
   logic             done_q;
   logic             err_q;

   logic [WIDTH-1:0] next;
   logic             ovf;
   logic             term;
   logic             fire;
   logic             start_acc;

   loop_index_step #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_step (
      .idx   (index_q),
      .step  (step_q),
      .op    (op_q),
      .limit (limit_q),
      .next  (next),
      .ovf   (ovf),
      .term  (term)
   );

   assign fire      = valid_q & i_ready;
   assign start_acc = (state == ST_IDLE) & i_start;

   // Main FSM: capture operands on start, advance on each handshake, and end
   // with a one-cycle done pulse once the step unit flags termination.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= ST_IDLE;
         limit_q <= '0;
         step_q  <= '0;
         op_q    <= '0;
         index_q <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  limit_q <= i_limit;
                  step_q  <= i_step;
                  op_q    <= i_op;
                  err_q   <= 1'b0;
                  if (i_init < i_limit) begin
                     state   <= ST_RUN;
                     valid_q <= 1'b1;
                     index_q <= i_init;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            default: begin
               if (fire) begin
                  if (term) begin
                     state   <= ST_IDLE;
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     // Hitting the limit is a clean end; anything else is an error.
                     err_q   <= ovf | (next <= index_q);
                  end else begin
                     index_q <= next;
                  end
               end
            end
         endcase
      end
   end

   assign o_busy  = (state == ST_RUN);
   assign o_valid = valid_q;
   assign o_index = index_q;
   assign o_last  = valid_q & term;
   assign o_done  = done_q;
   assign o_err   = err_q;

`ifdef LOOP_INDEX_GEN_COUNT_EN
   logic [WIDTH-1:0] count_q;

   // Element counter saturates instead of wrapping so a long run never reads small.
   always_ff @(posedge i_clk) begin
      if (i_rst || start_acc) begin
         count_q <= '0;
      end else if (fire && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign o_count = count_q;
`else
   logic unused_start_acc;
   assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_loop_index_gen.sv
// Self-checking bench for loop_index_gen (WIDTH=8) against a sequence-level model;
// also checks o_count when LOOP_INDEX_GEN_COUNT_EN is defined.
module tb_loop_index_gen;
   import loop_index_pkg::*;

   localparam int W = 8;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b1;
   logic         i_start = 1'b0;
   logic [W-1:0] i_init = '0;
   logic [W-1:0] i_limit = '0;
   logic [W-1:0] i_step = '0;
   logic [1:0]   i_op = 2'd0;
   logic         i_ready = 1'b0;
   logic         o_busy, o_valid, o_last, o_done, o_err;
   logic [W-1:0] o_index;
`ifdef LOOP_INDEX_GEN_COUNT_EN
   logic [W-1:0] o_count;
`endif

   int total = 0;
   int bad = 0;
   int ready_mode = 0;

   // model state, updated once per cycle on the falling edge
   bit known = 0;
   bit active = 0;
   bit exp_done = 0;
   bit exp_err = 0;
   bit seq_err = 0;
   int exp_cnt = 0;
   int exp_q[$];
   int observed[$];

   loop_index_gen #(.WIDTH(W)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (i_start),
      .i_init  (i_init),
      .i_limit (i_limit),
      .i_step  (i_step),
      .i_op    (i_op),
      .o_busy  (o_busy),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_index (o_index),
      .o_last  (o_last),
      .o_done  (o_done),
      .o_err   (o_err)
`ifdef LOOP_INDEX_GEN_COUNT_EN
      ,
      .o_count (o_count)
`endif
   );

   always #5 i_clk = ~i_clk;

   // Whole sequence from the loop semantics: integer arithmetic, range check after.
   function automatic void build_seq(input int init, input int limit, input int step,
                                     input int op, output int seq[$], output bit err);
      int a;
      int n;
      seq.delete();
      err = 0;
      a = init;
      if (a >= limit) return;
      for (int k = 0; k < 300; k++) begin
         seq.push_back(a);
         if (op == 1)      n = a * step;
         else if (op == 2) n = (step >= W) ? 256 : (a << step);
         else              n = a + step;
         if (n > 255 || n <= a) begin
            err = 1;
            return;
         end
         if (n >= limit) return;
         a = n;
      end
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkSeq(input string name, input int expected[$]);
      checkOutput({name, "_len"}, observed.size(), expected.size());
      for (int i = 0; i < expected.size() && i < observed.size(); i++)
         checkOutput({name, "_elem"}, observed[i], expected[i]);
   endtask

   // Compare process: check outputs against the model, then advance the model.
   always @(negedge i_clk) begin
      bit was_active;
      int seq[$];
      bit e;
      if (i_rst) begin
         known = 1;
         active = 0;
         exp_q.delete();
         exp_done = 0;
         exp_err = 0;
         exp_cnt = 0;
      end else if (known) begin
         checkOutput("valid", int'(o_valid), int'(active));
         checkOutput("busy", int'(o_busy), int'(active));
         checkOutput("done", int'(o_done), int'(exp_done));
         checkOutput("err", int'(o_err), int'(exp_err));
         if (active) begin
            checkOutput("index", int'(o_index), exp_q[0]);
            checkOutput("last", int'(o_last), int'(exp_q.size() == 1));
         end
`ifdef LOOP_INDEX_GEN_COUNT_EN
         checkOutput("count", int'(o_count), exp_cnt);
`endif
         was_active = active;
         exp_done = 0;
         if (active && i_ready) begin
            observed.push_back(int'(o_index));
            void'(exp_q.pop_front());
            if (exp_cnt < 255) exp_cnt++;
            if (exp_q.size() == 0) begin
               active = 0;
               exp_done = 1;
               exp_err = seq_err;
            end
         end
         if (i_start && !was_active) begin
            build_seq(int'(i_init), int'(i_limit), int'(i_step), int'(i_op), seq, e);
            exp_q = seq;
            seq_err = e;
            exp_err = 0;
            exp_cnt = 0;
            if (exp_q.size() > 0) active = 1;
            else exp_done = 1;
         end
      end
   end

   // Ready driver: 0 = held high, 1 = toggling, 2 = random (75% high).
   always @(posedge i_clk) begin
      #1;
      case (ready_mode)
         0: i_ready = 1'b1;
         1: i_ready = ~i_ready;
         default: i_ready = (($urandom % 4) != 0);
      endcase
   end

   task automatic pulseStart(input int init, input int limit, input int step, input int op);
      @(posedge i_clk);
      #1;
      i_start = 1'b1;
      i_init  = W'(init);
      i_limit = W'(limit);
      i_step  = W'(step);
      i_op    = 2'(op);
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
   endtask

   task automatic doReset();
      @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
   endtask

   task automatic waitIdle(input int max_cycles);
      int n = 0;
      while (active && n < max_cycles) begin
         @(posedge i_clk);
         #1;
         n++;
      end
      if (active) begin
         total++;
         bad++;
         $display("[TB] FAIL wait_idle actual=busy required=idle after %0d cycles", max_cycles);
         doReset();
      end
   endtask

   task automatic applyStimulus(input int init, input int limit, input int step, input int op);
      observed.delete();
      pulseStart(init, limit, step, op);
      waitIdle(600);
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      int exp[$];
      int s[$];
      bit e;
      int n;

      $display("[TB] loop_index_gen bench start");

      // model pinned by hand-computed sequences
      build_seq(0, 10, 1, 0, s, e);
      checkOutput("model_add_len", s.size(), 10);
      checkOutput("model_add_err", int'(e), 0);
      build_seq(1, 10, 2, 1, s, e);
      checkOutput("model_mul_len", s.size(), 4);
      checkOutput("model_mul_tail", s[3], 8);
      build_seq(250, 255, 10, 0, s, e);
      checkOutput("model_carry_err", int'(e), 1);
      build_seq(3, 200, 9, 2, s, e);
      checkOutput("model_shl_big_err", int'(e), 1);

      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      ready_mode = 0;
      @(posedge i_clk);
      #1;
      checkOutput("reset_valid", int'(o_valid), 0);
      checkOutput("reset_index", int'(o_index), 0);

      applyStimulus(0, 10, 1, 0);
      exp = {0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
      checkSeq("add_step1", exp);

      // toggling ready plus a start pulse that must be ignored while running
      ready_mode = 1;
      observed.delete();
      pulseStart(0, 10, 2, 0);
      repeat (2) @(posedge i_clk);
      #1;
      i_start = 1'b1;
      i_init  = 8'd1;
      i_limit = 8'd3;
      i_step  = 8'd1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      waitIdle(600);
      @(posedge i_clk);
      #1;
      exp = {0, 2, 4, 6, 8};
      checkSeq("add_step2_toggle", exp);

      ready_mode = 0;
      applyStimulus(1, 10, 2, 1);
      exp = {1, 2, 4, 8};
      checkSeq("mul_x2", exp);

      applyStimulus(0, 10, 2, 1);
      exp = {0};
      checkSeq("mul_init0", exp);

      applyStimulus(250, 255, 10, 0);
      exp = {250};
      checkSeq("add_carry", exp);

      applyStimulus(1, 200, 3, 2);
      exp = {1, 8, 64};
      checkSeq("shl_by3", exp);

      applyStimulus(5, 5, 1, 0);
      exp.delete();
      checkSeq("empty_range", exp);

      // reset after three fires, then a fresh start from its own init
      observed.delete();
      pulseStart(0, 100, 1, 3);
      n = 0;
      while (observed.size() < 3 && n < 50) begin
         @(posedge i_clk);
         #1;
         n++;
      end
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      exp = {0, 1, 2};
      checkSeq("reset_mid_run", exp);
      @(posedge i_clk);
      #1;
      checkOutput("post_reset_busy", int'(o_busy), 0);
      applyStimulus(7, 9, 1, 0);
      exp = {7, 8};
      checkSeq("restart", exp);

      // randomized sequences with random backpressure
      ready_mode = 2;
      for (int t = 0; t < 40; t++) begin
         int op;
         int init;
         int step;
         op = int'($urandom % 4);
         init = ($urandom % 3 == 0) ? int'($urandom % 256) : int'($urandom % 16);
         case (op)
            1: step = int'($urandom % 5);
            2: step = int'($urandom % 10);
            default: step = int'($urandom % 24);
         endcase
         applyStimulus(init, int'($urandom % 256), step, op);
      end

      repeat (3) @(posedge i_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
